// File: rtl/uart_cfg_sequencer.sv
// rtl/uart_cfg_sequencer.sv - line-coding change sequencer: drain, divide, load UART config
module uart_cfg_sequencer #(
   parameter int unsigned CLK_FREQ    = 60000000,
   parameter int unsigned TIMEOUT_CYC = 65535
) (
   input  logic        PHY_CLKOUT,
   input  logic        RESET_IN,
   input  logic        uart_en_i,
   input  logic [31:0] cfg_baud_i,
   input  logic [7:0]  cfg_stop_i,
   input  logic [7:0]  cfg_parity_i,
   input  logic [7:0]  cfg_data_bits_i,
   input  logic        uart_busy_i,
   input  logic        fifo_empty_i,
   output logic        uart_hold_o,
   output logic [15:0] div_o,
   output logic [2:0]  parity_o,
   output logic [1:0]  stop_o,
   output logic [3:0]  data_bits_o,
   output logic        cfg_load_o,
   output logic [4:0]  cfg_err_o
);

   // Reset divisor is the rounded divisor for the default 115200 baud request.
   localparam logic [63:0] DIV_RST_W = (64'(CLK_FREQ) + 64'd57600) / 64'd115200;
   localparam logic [15:0] DIV_RST   = DIV_RST_W[15:0];
   localparam logic [32:0] CLK_NUM   = 33'(CLK_FREQ);
   // Last DRAIN count value before the drain wait is abandoned.
   localparam logic [31:0] TO_LAST_W = (TIMEOUT_CYC == 0) ? 32'd0 : (32'(TIMEOUT_CYC) - 32'd1);
   localparam logic [15:0] TO_LAST   = TO_LAST_W[15:0];

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_DIVIDE = 2'd2,
      ST_LOAD   = 2'd3
   } state_t;

   state_t      state;

   // Last applied request, used for change detection.
   logic [31:0] shadow_baud;
   logic [7:0]  shadow_stop;
   logic [7:0]  shadow_parity;
   logic [7:0]  shadow_data_bits;

   // Request captured at the start of a sequence.
   logic [31:0] pend_baud;
   logic [7:0]  pend_stop;
   logic [7:0]  pend_parity;
   logic [7:0]  pend_data_bits;
   logic        pend_timeout;

   logic [15:0] drain_cnt;
   logic [5:0]  bit_cnt;
   logic [32:0] num_q;
   logic [31:0] rem_q;
   logic [32:0] quo_q;

   logic        cfg_diff;
   logic        uart_idle;
   logic [32:0] rem_shift;
   logic [32:0] rem_sub;
   logic        rem_ge;
   logic [15:0] div_next;
   logic        baud_bad;
   logic        parity_bad;
   logic        stop_bad;
   logic        data_bits_bad;

   // Change detection against the shadow and the drain exit condition.
   always_comb begin
      cfg_diff  = (cfg_baud_i != shadow_baud) || (cfg_stop_i != shadow_stop) ||
                  (cfg_parity_i != shadow_parity) || (cfg_data_bits_i != shadow_data_bits);
      uart_idle = !uart_busy_i && fifo_empty_i;
   end

   // One restoring-divider step: shift in the next numerator bit, subtract if it fits.
   always_comb begin
      rem_shift = {rem_q, num_q[32]};
      rem_ge    = (rem_shift >= {1'b0, pend_baud});
      rem_sub   = rem_shift - {1'b0, pend_baud};
   end

   // Validate the pending request and clamp the quotient into the usable divisor range.
   always_comb begin
      div_next = div_o;
      baud_bad = 1'b0;
      if (pend_baud == 32'd0) begin
         baud_bad = 1'b1;
      end else if (quo_q > 33'd65535) begin
         div_next = 16'hFFFF;
         baud_bad = 1'b1;
      end else if (quo_q < 33'd4) begin
         div_next = 16'd4;
         baud_bad = 1'b1;
      end else begin
         div_next = quo_q[15:0];
      end
      parity_bad    = (pend_parity > 8'd4);
      stop_bad      = (pend_stop > 8'd2);
      data_bits_bad = (pend_data_bits < 8'd5) || (pend_data_bits > 8'd8);
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge PHY_CLKOUT) begin
      if (RESET_IN) begin
         state            <= ST_IDLE;
         shadow_baud      <= 32'd115200;
         shadow_stop      <= 8'd0;
         shadow_parity    <= 8'd0;
         shadow_data_bits <= 8'd8;
         pend_baud        <= 32'd0;
         pend_stop        <= 8'd0;
         pend_parity      <= 8'd0;
         pend_data_bits   <= 8'd0;
         pend_timeout     <= 1'b0;
         drain_cnt        <= 16'd0;
         bit_cnt          <= 6'd0;
         num_q            <= 33'd0;
         rem_q            <= 32'd0;
         quo_q            <= 33'd0;
         uart_hold_o      <= 1'b0;
         div_o            <= DIV_RST;
         parity_o         <= 3'd0;
         stop_o           <= 2'd0;
         data_bits_o      <= 4'd8;
         cfg_load_o       <= 1'b0;
         cfg_err_o        <= 5'd0;
      end else begin
         cfg_load_o <= 1'b0;
         case (state)
            ST_IDLE: begin
               uart_hold_o <= 1'b0;
               if (uart_en_i && cfg_diff) begin
                  pend_baud      <= cfg_baud_i;
                  pend_stop      <= cfg_stop_i;
                  pend_parity    <= cfg_parity_i;
                  pend_data_bits <= cfg_data_bits_i;
                  pend_timeout   <= 1'b0;
                  drain_cnt      <= 16'd0;
                  uart_hold_o    <= 1'b1;
                  state          <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (uart_idle || (drain_cnt >= TO_LAST)) begin
                  // A timeout only counts when the UART is still not idle.
                  pend_timeout <= !uart_idle;
                  num_q        <= CLK_NUM + {2'b00, pend_baud[31:1]};
                  rem_q        <= 32'd0;
                  quo_q        <= 33'd0;
                  bit_cnt      <= 6'd0;
                  state        <= ST_DIVIDE;
               end else begin
                  drain_cnt <= drain_cnt + 16'd1;
               end
            end
            ST_DIVIDE: begin
               if (pend_baud == 32'd0) begin
                  state <= ST_LOAD;
               end else begin
                  num_q <= {num_q[31:0], 1'b0};
                  rem_q <= rem_ge ? rem_sub[31:0] : rem_shift[31:0];
                  quo_q <= {quo_q[31:0], rem_ge};
                  if (bit_cnt == 6'd32) begin
                     state <= ST_LOAD;
                  end else begin
                     bit_cnt <= bit_cnt + 6'd1;
                  end
               end
            end
            ST_LOAD: begin
               div_o <= div_next;
               if (!parity_bad) begin
                  parity_o <= pend_parity[2:0];
               end
               if (!stop_bad) begin
                  stop_o <= pend_stop[1:0];
               end
               if (!data_bits_bad) begin
                  data_bits_o <= pend_data_bits[3:0];
               end
               cfg_err_o        <= {pend_timeout, data_bits_bad, stop_bad, parity_bad, baud_bad};
               cfg_load_o       <= 1'b1;
               uart_hold_o      <= 1'b0;
               shadow_baud      <= pend_baud;
               shadow_stop      <= pend_stop;
               shadow_parity    <= pend_parity;
               shadow_data_bits <= pend_data_bits;
               state            <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: doc/uart_cfg_sequencer.md
UART_CFG_SEQUENCER -- requirements
Module: uart_cfg_sequencer

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- CLK_FREQ, 60000000, PHY_CLKOUT frequency in Hz.
- TIMEOUT_CYC, 65535, maximum number of DRAIN cycles before the load is forced.

REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- PHY_CLKOUT, in, 1, the single clock.
- RESET_IN, in, 1, reset; synchronous and active-high.
- uart_en_i, in, 1, channel enable (DTR).
- cfg_baud_i, in, 32, requested dwDTERate.
- cfg_stop_i, in, 8, bCharFormat.
- cfg_parity_i, in, 8, bParityType.
- cfg_data_bits_i, in, 8, bDataBits.
- uart_busy_i, in, 1, UART TX or RX shifter active.
- fifo_empty_i, in, 1, UART TX FIFO empty.
- uart_hold_o, out, 1, UART must not start a new character.
- div_o, out, 16, baud divisor.
- parity_o, out, 3, parity mode: 0 none, 1 odd, 2 even, 3 mark, 4 space.
- stop_o, out, 2, stop bits: 0 = 1, 1 = 1.5, 2 = 2.
- data_bits_o, out, 4, character length, 5..8.
- cfg_load_o, out, 1, one-cycle apply strobe.
- cfg_err_o, out, 5, status of the last load: [0] baud, [1] parity, [2] stop, [3] data bits, [4] drain timeout.

Function
REQ-003 The block SHALL keep shadow registers holding the last applied request (baud, stop, parity, data bits).
REQ-004 The block SHALL implement exactly four states: IDLE, DRAIN, DIVIDE, LOAD.
REQ-005 IDLE: when uart_en_i=1 and any cfg_* input differs from its shadow, the block SHALL capture all cfg_* inputs into pending registers, set uart_hold_o=1 on the next cycle, and enter DRAIN.
- With uart_en_i=0, change detection SHALL be disabled.
REQ-006 DRAIN: the block SHALL go to DIVIDE in the first cycle with uart_busy_i=0 and fifo_empty_i=1; a 16-bit counter SHALL force DIVIDE after TIMEOUT_CYC cycles and set pending error bit [4].
REQ-007 DIVIDE: the block SHALL compute floor((CLK_FREQ + baud/2) / baud) with a 33-bit-numerator restoring divider, one quotient bit per cycle, exactly 33 cycles.
REQ-008 Baud = 0 SHALL skip the divide (1 cycle in DIVIDE), keep div_o, and set error [0].
REQ-009 A quotient > 65535 SHALL clamp to 65535 with error [0]; a quotient < 4 SHALL clamp to 4 with error [0].
REQ-010 Parity > 4 SHALL keep the previous parity_o and set error [1]; stop > 2 SHALL keep the previous stop_o and set error [2]; data bits outside 5..8 SHALL keep the previous data_bits_o and set error [3].
REQ-011 LOAD (one cycle): the block SHALL update div_o, parity_o, stop_o, data_bits_o and cfg_err_o, pulse cfg_load_o=1, copy the pending request into the shadow, then return to IDLE.
- uart_hold_o SHALL be 0 from the first IDLE cycle after LOAD.
REQ-012 The block SHALL hold uart_hold_o=1 in DRAIN, DIVIDE and LOAD only.
REQ-013 Latency SHALL be: input change -> LOAD = 1 + DRAIN cycles + 33 + 1; with the UART idle, cfg_load_o SHALL be high exactly in cycle 36 after the change cycle.
REQ-014 Inputs changing during DRAIN/DIVIDE/LOAD SHALL be ignored; the sequence completes with the captured values, and IDLE then re-detects the difference and starts a new sequence.
REQ-015 uart_en_i falling mid-sequence SHALL NOT abort the sequence.
REQ-016 Outputs SHALL be registered; cfg_load_o SHALL never be high for two consecutive cycles.

Reset
REQ-017 On RESET_IN=1 at a clock edge the block SHALL enter IDLE and set: shadow = {115200, 0, 0, 8}, div_o = 521 (default CLK_FREQ), parity_o=0, stop_o=0, data_bits_o=8, uart_hold_o=0, cfg_load_o=0, cfg_err_o=0, counters=0.
REQ-018 Reset mid-sequence SHALL discard the pending request and SHALL NOT produce cfg_load_o.

Verification
REQ-019 Reset, inputs {115200,0,0,8}, uart_en_i=1 for 200 cycles -> no uart_hold_o, no cfg_load_o, div_o=521.
REQ-020 Baud 9600, UART idle -> uart_hold_o=1 next cycle, single cfg_load_o at cycle 36, div_o=6250, cfg_err_o=0, hold released the following cycle.
REQ-021 Baud 57600 with uart_busy_i=1 for 100 cycles -> load 35 cycles after busy falls, div_o=1042; with TIMEOUT_CYC=50 -> forced load, cfg_err_o[4]=1.
REQ-022 Baud 0 -> div_o unchanged, cfg_err_o=5'b00001; then baud 100 -> div_o=65535, cfg_err_o[0]=1.
REQ-023 Parity 7, stop 1, data bits 16 -> parity_o and data_bits_o unchanged, stop_o=1, cfg_err_o=5'b01010.
REQ-024 RESET_IN pulsed at cycle 10 of DIVIDE -> all outputs at reset values, no cfg_load_o; baud changed during DIVIDE -> two loads back-to-back, final div_o matches the second value.
